bcd_seg7_scan: RTL

Display stage directly downstream of the byte-to-BCD converter. Captures the three BCD digits (hundreds/tens/ones) on a load strobe and time-multiplexes them onto the board's 4-digit common-anode 7-segment display. Supports optional leading-zero blanking and whole-display blink. All outputs are active-low and registered.

---
 rtl/bcd_seg7_scan.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/bcd_seg7_scan.sv
// Three-digit BCD display driver for a 4-digit common-anode 7-segment module.
// Shadows the digits on a load strobe, scans one anode at a time, with optional
// leading-zero blanking and whole-display blink. All outputs are active-low.
module bcd_seg7_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [1:0] hundreds,
  input  logic       lz_blank,
  input  logic       blink,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_DARK = 7'b1111111;
  localparam logic [3:0] AN_DARK  = 4'b1111;

  // Slot 3 is never lit; it exists so every digit gets a 1/4 duty cycle.
  typedef enum logic [1:0] {
    SLOT_ONES = 2'd0,
    SLOT_TENS = 2'd1,
    SLOT_HUND = 2'd2,
    SLOT_DARK = 2'd3
  } slot_e;

  function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg7_decode = 7'b1000000;
      4'd1:    seg7_decode = 7'b1111001;
      4'd2:    seg7_decode = 7'b0100100;
      4'd3:    seg7_decode = 7'b0110000;
      4'd4:    seg7_decode = 7'b0011001;
      4'd5:    seg7_decode = 7'b0010010;
      4'd6:    seg7_decode = 7'b0000010;
      4'd7:    seg7_decode = 7'b1111000;
      4'd8:    seg7_decode = 7'b0000000;
      4'd9:    seg7_decode = 7'b0010000;
      default: seg7_decode = 7'b0111111;
    endcase
  endfunction

  logic [3:0]    ones_q, ones_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    hund_q, hund_d;
  logic [RW-1:0] refresh_q, refresh_d;
  slot_e         slot_q, slot_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;

  logic [3:0]    digit;
  logic          slot_lit;

  // NOTE: every signal assigned here gets a default first, so no path can leave
  // a value unassigned and infer a latch.
  always_comb begin
    ones_d      = ones_q;
    tens_d      = tens_q;
    hund_d      = hund_q;
    refresh_d   = refresh_q + RW'(1);
    slot_d      = slot_q;
    blink_cnt_d = '0;
    blink_on_d  = 1'b1;
    digit       = ones_q;
    slot_lit    = 1'b0;
    seg_d       = SEG_DARK;
    an_d        = AN_DARK;

    if (load) begin
      ones_d = ones;
      tens_d = tens;
      hund_d = {2'b00, hundreds};
    end

    if (refresh_q == REFRESH_LAST) begin
      refresh_d = '0;
      slot_d    = slot_e'(slot_q + 2'd1);
    end

    // Dropping blink clears the counter and forces the phase on immediately.
    if (blink) begin
      blink_on_d = blink_on_q;
      if (blink_cnt_q == BLINK_LAST) begin
        blink_on_d = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end

    case (slot_q)
      SLOT_ONES: begin
        digit    = ones_q;
        slot_lit = 1'b1;
      end
      SLOT_TENS: begin
        digit    = tens_q;
        slot_lit = !(lz_blank && hund_q == 4'd0 && tens_q == 4'd0);
      end
      SLOT_HUND: begin
        digit    = hund_q;
        slot_lit = !(lz_blank && hund_q == 4'd0);
      end
      default: begin
        digit    = ones_q;
        slot_lit = 1'b0;
      end
    endcase

    // Blanked or blinked-off slots also darken the segments to avoid ghosting.
    if (slot_lit && blink_on_q) begin
      seg_d = seg7_decode(digit);
      an_d  = ~(4'b0001 << slot_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q      <= '0;
      tens_q      <= '0;
      hund_q      <= '0;
      refresh_q   <= '0;
      slot_q      <= SLOT_ONES;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      seg_q       <= SEG_DARK;
      an_q        <= AN_DARK;
    end else begin
      ones_q      <= ones_d;
      tens_q      <= tens_d;
      hund_q      <= hund_d;
      refresh_q   <= refresh_d;
      slot_q      <= slot_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = 1'b1;

endmodule
